// File: rtl/clock_pkg.sv
// Shared types and BCD constants for the clock set/alarm controller.
package clock_pkg;

  typedef enum logic [2:0] {
    RUN,
    SET_HH,
    SET_MM,
    AL_HH,
    AL_MM
  } state_e;

  typedef enum logic {
    FLD_MIN,
    FLD_HR
  } fld_e;

  localparam logic [7:0] HR_MIN  = 8'h01;
  localparam logic [7:0] HR_MAX  = 8'h12;
  localparam logic [7:0] MIN_MAX = 8'h59;

  localparam logic [1:0] BLINK_NONE = 2'b00;
  localparam logic [1:0] BLINK_HH   = 2'b01;
  localparam logic [1:0] BLINK_MM   = 2'b10;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] >= 4'h9) r = {v[7:4] + 4'h1, 4'h0};
    else                r = {v[7:4], v[3:0] + 4'h1};
    return r;
  endfunction

endpackage

// File: rtl/bcd_field_inc.sv
// One-step BCD increment for a 12-hour hour field or a 00..59 minute field.
module bcd_field_inc
  import clock_pkg::*;
(
  input  logic [7:0] value_i,
  input  fld_e       mode_i,
  output logic [7:0] next_o,
  output logic       pm_toggle_o
);

  always_comb begin
    next_o      = bcd_inc(value_i);
    pm_toggle_o = 1'b0;
    unique case (1'b1)
      (mode_i == FLD_HR): begin
        if (value_i == HR_MAX) next_o = HR_MIN;
        pm_toggle_o = (value_i == 8'h11);
      end
      default: begin
        if (value_i == MIN_MAX) next_o = 8'h00;
      end
    endcase
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Set/alarm control FSM for the 12-hour BCD clock_timer: shadow edits,
// load strobe, timer gating, display mux and alarm ring.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned TIMEOUT_TICKS = 16,
  parameter logic [7:0]  AL_DEF_HH     = 8'h07,
  parameter logic [7:0]  AL_DEF_MM     = 8'h00,
  parameter logic        AL_DEF_PM     = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       alarm_en,
  input  logic [7:0] hh,
  input  logic [7:0] mm,
  input  logic [7:0] ss,
  input  logic       pm,
  output logic       ena,
  output logic       ld,
  output logic [7:0] ld_hh,
  output logic [7:0] ld_mm,
  output logic       ld_pm,
  output logic [7:0] disp_hh,
  output logic [7:0] disp_mm,
  output logic       disp_pm,
  output logic [1:0] blink,
  output logic       ring
);

  localparam int unsigned TW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_TICKS - 1);

  state_e        state_q;
  logic [7:0]    sh_hh_q, sh_mm_q;
  logic          sh_pm_q;
  logic [7:0]    al_hh_q, al_mm_q;
  logic          al_pm_q;
  logic          ld_q;
  logic [7:0]    ld_hh_q, ld_mm_q;
  logic          ld_pm_q;
  logic          ring_q;
  logic          fired_q;
  logic [5:0]    rcnt_q;
  logic [TW-1:0] tmo_q;

  logic       in_run, in_set, in_al, edit_hr;
  logic       press, min_match, fire;
  logic [7:0] fld_src, fld_nxt;
  logic       pm_tog;
  fld_e       fld_mode;

  assign in_run  = (state_q == RUN);
  assign in_set  = (state_q == SET_HH) || (state_q == SET_MM);
  assign in_al   = (state_q == AL_HH) || (state_q == AL_MM);
  assign edit_hr = (state_q == SET_HH) || (state_q == AL_HH);
  assign press   = btn_mode | btn_inc;

  assign min_match = (hh == al_hh_q) && (mm == al_mm_q) && (pm == al_pm_q);
  // fired_q blocks a second ring within the same matching minute
  assign fire = in_run && alarm_en && min_match && (ss == 8'h00)
             && !fired_q && !ring_q;

  always_comb begin
    fld_src = 8'h00;
    unique case (state_q)
      SET_HH:  fld_src = sh_hh_q;
      SET_MM:  fld_src = sh_mm_q;
      AL_HH:   fld_src = al_hh_q;
      AL_MM:   fld_src = al_mm_q;
      default: fld_src = 8'h00;
    endcase
  end

  assign fld_mode = edit_hr ? FLD_HR : FLD_MIN;

  bcd_field_inc u_inc (
    .value_i    (fld_src),
    .mode_i     (fld_mode),
    .next_o     (fld_nxt),
    .pm_toggle_o(pm_tog)
  );

  assign ena   = tick_1hz && !ld_q && (in_run || in_al);
  assign ld    = ld_q;
  assign ld_hh = ld_hh_q;
  assign ld_mm = ld_mm_q;
  assign ld_pm = ld_pm_q;
  assign ring  = ring_q;

  always_comb begin
    disp_hh = hh;
    disp_mm = mm;
    disp_pm = pm;
    blink   = BLINK_NONE;
    unique case (1'b1)
      in_set: begin
        disp_hh = sh_hh_q;
        disp_mm = sh_mm_q;
        disp_pm = sh_pm_q;
      end
      in_al: begin
        disp_hh = al_hh_q;
        disp_mm = al_mm_q;
        disp_pm = al_pm_q;
      end
      default: ;
    endcase
    if (edit_hr)                   blink = BLINK_HH;
    else if (!in_run && !in_set
             && state_q != AL_MM)  blink = BLINK_NONE;
    else if (!in_run)              blink = BLINK_MM;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      sh_hh_q <= 8'h12;
      sh_mm_q <= 8'h00;
      sh_pm_q <= 1'b0;
      al_hh_q <= AL_DEF_HH;
      al_mm_q <= AL_DEF_MM;
      al_pm_q <= AL_DEF_PM;
      ld_q    <= 1'b0;
      ld_hh_q <= 8'h12;
      ld_mm_q <= 8'h00;
      ld_pm_q <= 1'b0;
      ring_q  <= 1'b0;
      fired_q <= 1'b0;
      rcnt_q  <= '0;
      tmo_q   <= '0;
    end else begin
      ld_q <= 1'b0;

      if (ring_q) begin
        if (tick_1hz) rcnt_q <= rcnt_q + 6'd1;
        if (press || !alarm_en || !in_run
            || (tick_1hz && rcnt_q == 6'd59))
          ring_q <= 1'b0;
      end else if (fire) begin
        ring_q  <= 1'b1;
        fired_q <= 1'b1;
        rcnt_q  <= '0;
      end
      if (!min_match) fired_q <= 1'b0;

      // a press that silences the ring does nothing else
      if (ring_q && press) begin
        tmo_q <= '0;
      end else if (btn_mode) begin
        tmo_q <= '0;
        unique case (state_q)
          RUN: begin
            sh_hh_q <= hh;
            sh_mm_q <= mm;
            sh_pm_q <= pm;
            state_q <= SET_HH;
          end
          SET_HH: state_q <= SET_MM;
          SET_MM: begin
            ld_q    <= 1'b1;
            ld_hh_q <= sh_hh_q;
            ld_mm_q <= sh_mm_q;
            ld_pm_q <= sh_pm_q;
            state_q <= AL_HH;
          end
          AL_HH:   state_q <= AL_MM;
          AL_MM:   state_q <= RUN;
          default: state_q <= RUN;
        endcase
      end else if (btn_inc) begin
        tmo_q <= '0;
        unique case (state_q)
          SET_HH: begin
            sh_hh_q <= fld_nxt;
            sh_pm_q <= sh_pm_q ^ pm_tog;
          end
          SET_MM: sh_mm_q <= fld_nxt;
          AL_HH: begin
            al_hh_q <= fld_nxt;
            al_pm_q <= al_pm_q ^ pm_tog;
          end
          AL_MM:   al_mm_q <= fld_nxt;
          default: ;
        endcase
      end else if (!in_run && tick_1hz) begin
        if (tmo_q == TMO_LAST) begin
          state_q <= RUN;
          tmo_q   <= '0;
        end else begin
          tmo_q <= tmo_q + TW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Scoreboard bench for clock_set_ctrl: directed stimulus, queued expectations.
module tb_clock_set_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic       alarm_en = 1'b0;
  logic [7:0] hh = 8'h11;
  logic [7:0] mm = 8'h30;
  logic [7:0] ss = 8'h15;
  logic       pm = 1'b0;
  logic       ena, ld, ld_pm, disp_pm, ring;
  logic [7:0] ld_hh, ld_mm, disp_hh, disp_mm;
  logic [1:0] blink;

  clock_set_ctrl dut (
    .clk(clk), .reset_n(reset_n), .tick_1hz(tick_1hz),
    .btn_mode(btn_mode), .btn_inc(btn_inc), .alarm_en(alarm_en),
    .hh(hh), .mm(mm), .ss(ss), .pm(pm),
    .ena(ena), .ld(ld), .ld_hh(ld_hh), .ld_mm(ld_mm), .ld_pm(ld_pm),
    .disp_hh(disp_hh), .disp_mm(disp_mm), .disp_pm(disp_pm),
    .blink(blink), .ring(ring)
  );

  always #5 clk = ~clk;

  localparam int S_ENA = 0, S_RING = 1, S_BLINK = 2, S_DHH = 3;
  localparam int S_DMM = 4, S_DPM = 5, S_LD = 6;

  typedef struct {
    string       name;
    int          sel;
    logic [16:0] v;
  } chk_t;

  chk_t        cq[$];
  logic [16:0] ldq[$];
  int          errors = 0;
  int          checks = 0;

  function automatic logic [16:0] probe(input int sel);
    case (sel)
      S_ENA:   return 17'(ena);
      S_RING:  return 17'(ring);
      S_BLINK: return 17'(blink);
      S_DHH:   return 17'(disp_hh);
      S_DMM:   return 17'(disp_mm);
      S_DPM:   return 17'(disp_pm);
      S_LD:    return 17'(ld);
      default: return 17'h1ffff;
    endcase
  endfunction

  chk_t        c;
  logic [16:0] lw;
  always @(negedge clk) begin
    while (cq.size() > 0) begin
      c = cq.pop_front();
      checks++;
      if (probe(c.sel) !== c.v) begin
        errors++;
        $display("FAIL %s got=%h want=%h", c.name, probe(c.sel), c.v);
      end
    end
    if (ld !== 1'b0) begin
      checks++;
      if (ldq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ld got=%h_%h_%b want=none",
                 ld_hh, ld_mm, ld_pm);
      end else begin
        lw = ldq.pop_front();
        if ({ld_hh, ld_mm, ld_pm} !== lw) begin
          errors++;
          $display("FAIL ld_value got=%h want=%h",
                   {ld_hh, ld_mm, ld_pm}, lw);
        end
      end
    end
  end

  task automatic want(input string n, input int sel, input logic [16:0] v);
    chk_t e;
    e.name = n;
    e.sel  = sel;
    e.v    = v;
    cq.push_back(e);
  endtask

  task automatic want_ld(input logic [7:0] h, input logic [7:0] m,
                         input logic p);
    ldq.push_back({h, m, p});
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pmode();
    btn_mode = 1'b1;
    cyc();
    btn_mode = 1'b0;
  endtask

  task automatic pinc();
    btn_inc = 1'b1;
    cyc();
    btn_inc = 1'b0;
  endtask

  task automatic tick();
    tick_1hz = 1'b1;
    cyc();
    tick_1hz = 1'b0;
  endtask

  task automatic tick_ena0();
    tick_1hz = 1'b1;
    want("ena_frozen", S_ENA, 17'h0);
    cyc();
    tick_1hz = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    cyc(); cyc();
    want("rst_ring", S_RING, 17'h0);
    want("rst_ld", S_LD, 17'h0);
    want("rst_blink", S_BLINK, 17'h0);
    want("rst_ena", S_ENA, 17'h0);
    want("rst_disp_hh", S_DHH, 17'h11);
    cyc();
    reset_n = 1'b1;
    cyc();

    // reset mid-edit
    pmode();
    want("seth_blink", S_BLINK, 17'h1);
    want("capture_hh", S_DHH, 17'h11);
    pinc();
    want("inc_11_12", S_DHH, 17'h12);
    want("inc_11_pm", S_DPM, 17'h1);
    cyc();
    reset_n = 1'b0;
    want("mid_rst_blink", S_BLINK, 17'h0);
    want("mid_rst_ring", S_RING, 17'h0);
    want("mid_rst_ld", S_LD, 17'h0);
    want("mid_rst_ena", S_ENA, 17'h0);
    want("mid_rst_disp", S_DHH, 17'h11);
    want("mid_rst_pm", S_DPM, 17'h0);
    cyc(); cyc();
    reset_n = 1'b1;
    cyc();
    pmode();
    pmode();
    want_ld(8'h11, 8'h30, 1'b0);
    pmode();
    tick_1hz = 1'b1;
    want("ena_ld_cycle", S_ENA, 17'h0);
    cyc();
    tick_1hz = 1'b0;
    want("alh_blink", S_BLINK, 17'h1);
    want("al_def_hh", S_DHH, 17'h07);
    want("al_def_mm", S_DMM, 17'h00);
    want("al_def_pm", S_DPM, 17'h0);
    tick_1hz = 1'b1;
    want("ena_al_run", S_ENA, 17'h1);
    cyc();
    tick_1hz = 1'b0;
    pmode();
    want("alm_blink", S_BLINK, 17'h2);
    pmode();
    want("run_blink", S_BLINK, 17'h0);
    cyc();

    // hour wrap 11 -> 12 PM -> 01 PM
    pmode();
    pinc();
    want("wrap_12", S_DHH, 17'h12);
    want("wrap_12_pm", S_DPM, 17'h1);
    pinc();
    want("wrap_01", S_DHH, 17'h01);
    want("wrap_01_pm", S_DPM, 17'h1);
    pmode();
    want_ld(8'h01, 8'h30, 1'b1);
    pmode();
    pmode();
    pmode();
    want("wrap_back_run", S_BLINK, 17'h0);
    cyc();

    // minute wrap and timer freeze
    hh = 8'h03; mm = 8'h59; pm = 1'b1;
    cyc();
    pmode();
    pmode();
    want("setm_blink", S_BLINK, 17'h2);
    want("setm_59", S_DMM, 17'h59);
    pinc();
    want("min_wrap_00", S_DMM, 17'h00);
    want("min_no_carry", S_DHH, 17'h03);
    want("min_pm_kept", S_DPM, 17'h1);
    for (int i = 0; i < 5; i++) tick_ena0();
    for (int i = 0; i < 9; i++) pinc();
    want("min_09", S_DMM, 17'h09);
    pinc();
    want("min_09_10", S_DMM, 17'h10);
    want_ld(8'h03, 8'h10, 1'b1);
    pmode();
    pmode();
    pmode();
    cyc();

    // timeout discards edits
    hh = 8'h05; mm = 8'h20; pm = 1'b0;
    cyc();
    pmode();
    pinc();
    want("tmo_edit", S_DHH, 17'h06);
    for (int i = 0; i < 15; i++) tick();
    want("tmo_15_hold", S_BLINK, 17'h1);
    cyc();
    tick();
    want("tmo_run", S_BLINK, 17'h0);
    want("tmo_disp_hh", S_DHH, 17'h05);
    want("tmo_disp_mm", S_DMM, 17'h20);
    cyc(); cyc();

    // simultaneous buttons
    pmode();
    btn_mode = 1'b1;
    btn_inc  = 1'b1;
    cyc();
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    want("both_setm", S_BLINK, 17'h2);
    want("both_hh_kept", S_DHH, 17'h05);
    want_ld(8'h05, 8'h20, 1'b0);
    pmode();
    pmode();
    pmode();
    cyc();

    // alarm fire and silence
    hh = 8'h07; mm = 8'h00; pm = 1'b0; ss = 8'h59;
    alarm_en = 1'b1;
    cyc(); cyc();
    want("ring_pre", S_RING, 17'h0);
    cyc();
    ss = 8'h00;
    cyc();
    want("ring_fire", S_RING, 17'h1);
    cyc();
    pinc();
    want("ring_silenced", S_RING, 17'h0);
    want("silence_no_state", S_BLINK, 17'h0);
    cyc(); cyc();
    want("ring_no_retrig", S_RING, 17'h0);
    cyc();
    mm = 8'h01;
    cyc();
    mm = 8'h00;
    cyc();
    want("ring_refire", S_RING, 17'h1);
    cyc();
    for (int i = 0; i < 59; i++) tick();
    want("ring_59_ticks", S_RING, 17'h1);
    cyc();
    tick();
    want("ring_60_ticks", S_RING, 17'h0);
    cyc();
    alarm_en = 1'b0;
    ss = 8'h01;
    pmode();
    pmode();
    want_ld(8'h07, 8'h00, 1'b0);
    pmode();
    want("al_kept_hh", S_DHH, 17'h07);
    want("al_kept_mm", S_DMM, 17'h00);
    pinc();
    want("al_inc_hh", S_DHH, 17'h08);
    pmode();
    pmode();
    cyc();

    // alarm_en drop silences
    hh = 8'h08; mm = 8'h00; ss = 8'h00; pm = 1'b0;
    alarm_en = 1'b1;
    cyc();
    want("ring_al08", S_RING, 17'h1);
    cyc();
    alarm_en = 1'b0;
    cyc();
    want("ring_en_off", S_RING, 17'h0);
    cyc(); cyc(); cyc();

    checks++;
    if (ldq.size() != 0) begin
      errors++;
      $display("FAIL missing_ld got=%0d want=0", ldq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
- Control FSM for the 12-hour BCD clock_timer. It lets a user set the time and an alarm from two debounced buttons, and gates the timer enable.
- While setting, it holds edited values in shadow registers, then commits them to clock_timer through a one-cycle load strobe.
- It compares the running time against the alarm and drives a ring output.
- It sits between the button debouncers, clock_timer and the display driver.

Parameters:
- TIMEOUT_TICKS, 16: tick_1hz pulses with no button press before any SET state aborts back to RUN.
- AL_DEF_HH, 8'h07: alarm hour after reset (BCD, 01..12).
- AL_DEF_MM, 8'h00: alarm minute after reset (BCD, 00..59).
- AL_DEF_PM, 1'b0: alarm AM/PM after reset.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- tick_1hz  in  1  one-cycle seconds strobe
- btn_mode  in  1  debounced one-cycle press pulse
- btn_inc  in  1  debounced one-cycle press pulse
- alarm_en  in  1  level; alarm armed when 1
- hh  in  8  timer hours, BCD
- mm  in  8  timer minutes, BCD
- ss  in  8  timer seconds, BCD
- pm  in  1  timer PM flag
- ena  out  1  enable to clock_timer
- ld  out  1  one-cycle load strobe to clock_timer (timer loads ld_hh/ld_mm/ld_pm and forces ss=00)
- ld_hh  out  8  BCD hour value to load
- ld_mm  out  8  BCD minute value to load
- ld_pm  out  1  PM flag value to load
- disp_hh  out  8  BCD hour to display
- disp_mm  out  8  BCD minute to display
- disp_pm  out  1  PM flag to display
- blink  out  2  field being edited: 00 none, 01 hours, 10 minutes
- ring  out  1  alarm sounding

Behaviour:
- One clock domain, clk. Reset is asynchronous and active-low on reset_n. All flops clear immediately on reset_n=0 and reset values apply until the first clk edge after reset_n=1.
- Reset values:
  - state=RUN; ena=0, ld=0, ring=0, blink=00.
  - ld_hh=8'h12, ld_mm=8'h00, ld_pm=0.
  - Shadow registers = 12:00 AM.
  - Alarm registers = AL_DEF_*.
  - Timeout counter = 0.
- States: RUN, SET_HH, SET_MM, AL_HH, AL_MM.
- Transitions, all on btn_mode:
  - RUN -> SET_HH: capture hh/mm/pm into the shadow registers that same edge.
  - SET_HH -> SET_MM.
  - SET_MM -> AL_HH: ld=1 for exactly one cycle, with ld_hh/ld_mm/ld_pm = shadow values, registered.
  - AL_HH -> AL_MM.
  - AL_MM -> RUN.
- btn_inc in SET_HH or AL_HH:
  - Hour increments 01..11 -> next; 11 -> 12 also toggles the PM flag; 12 -> 01 with no PM toggle.
  - BCD digit rule: 09 -> 10.
- btn_inc in SET_MM or AL_MM: minute increments 00..59 BCD, 59 -> 00, no carry into hours.
- btn_inc in RUN with ring=0: ignored.
- Both buttons pressed in the same cycle: btn_mode wins and btn_inc is dropped.
- ena:
  - ena = tick_1hz in RUN, AL_HH and AL_MM; the timer keeps running while the alarm is being set.
  - ena = 0 in SET_HH and SET_MM, and on the ld cycle.
  - ena is combinational from state and tick_1hz.
- Display mux:
  - RUN: disp_* = hh/mm/pm.
  - SET_*: disp_* = shadow registers.
  - AL_*: disp_* = alarm registers.
  - blink = 01 in SET_HH and AL_HH, 10 in SET_MM and AL_MM, 00 in RUN.
- Timeout:
  - The counter clears on any button press or any state change, and increments on tick_1hz in SET and AL states.
  - When the counter reaches TIMEOUT_TICKS: go to RUN and discard edits. No ld is issued. Alarm edits already written stay in effect.
- Alarm:
  - Match condition: state=RUN, alarm_en=1, hh==al_hh, mm==al_mm, pm==al_pm and ss==8'h00. On match, ring is set on the next edge.
  - ring holds until any button press, alarm_en=0, or 60 tick_1hz pulses.
  - A press that silences ring is consumed: no state change and no increment.
  - ring cannot retrigger while still in the matching minute.
  - Leaving RUN clears ring.
- Reset mid-operation, including mid-edit: all edits are lost, and no ld is issued at or after reset.

Decomposition:
- Package clock_pkg:
  - State enum.
  - BCD constants: HR_MIN=8'h01, HR_MAX=8'h12, MIN_MAX=8'h59.
  - Blink encodings.
- Sub-module bcd_field_inc, combinational, used for both hours and minutes:
  - Inputs: value, mode (hour/minute).
  - Outputs: next value, pm_toggle.

Test Plan:
- Reset mid-edit: assert reset_n=0 while in SET_HH -> state=RUN, ring=0, ena=0, ld=0; after reset_n=1, AL_HH/AL_MM show 07:00 AM (blink=01 in AL_HH).
- Hour wrap: capture 11:30 AM, then mode, inc x2 -> shadow reads 12 PM, then 01 PM; mode, mode -> ld pulse exactly one cycle with ld_hh=8'h01, ld_mm=8'h30, ld_pm=1.
- Minute wrap and freeze: SET_MM at 59, then inc -> 00 with hours unchanged; ena stays 0 across 5 ticks in SET states.
- Timeout: enter SET_HH, press inc once, send 16 ticks with no press -> RUN, no ld ever, timer value unchanged.
- Alarm fire: alarm 07:00 AM, timer reaches 07:00:00 AM with alarm_en=1 -> ring=1 next cycle; btn_inc -> ring=0 with no increment; same scenario without a press -> ring drops after 60 ticks.
- Simultaneous buttons: btn_mode and btn_inc in the same cycle in SET_HH -> goes to SET_MM, shadow hour unchanged.
